fifo_wr_arbiter: RTL

//  Single-clock controller and round-robin write arbiter for the fifomem dual-port array.

---
 rtl/fifo_wr_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter and pointer/status controller for a shared fifomem array.
// Grants at most one requester per cycle; first-word-fall-through read side.
module fifo_wr_arbiter #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 4,
    parameter int unsigned NREQ     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     rd_en,
    output logic                     wclken,
    output logic [ADDRSIZE-1:0]      waddr,
    output logic [DATASIZE-1:0]      wdata,
    output logic [ADDRSIZE-1:0]      raddr,
    output logic                     wfull,
    output logic                     full,
    output logic                     empty,
    output logic [ADDRSIZE:0]        count,
    output logic                     rd_err
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic [IW-1:0]     last_gnt;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     cand;
    logic              gnt_any;
    logic              rd_ok;

    // Flags derive only from registered pointers; the extra MSB separates full from empty.
    assign empty  = (wptr == rptr);
    assign full   = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                    (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
    assign count  = wptr - rptr;
    assign wfull  = full;
    assign waddr  = wptr[ADDRSIZE-1:0];
    assign raddr  = rptr[ADDRSIZE-1:0];
    assign wclken = gnt_any;
    assign rd_ok  = rd_en && !empty;

    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = last_gnt;
        cand    = last_gnt;
        if (!full) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                cand = IW'((int'(last_gnt) + k) % int'(NREQ));
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        gnt   = '0;
        wdata = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
            wdata        = req_data[int'(gnt_idx)*int'(DATASIZE) +: DATASIZE];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            last_gnt <= IW'(NREQ - 1);
            rd_err   <= 1'b0;
        end else begin
            if (gnt_any) begin
                wptr     <= wptr + (ADDRSIZE+1)'(1);
                last_gnt <= gnt_idx;
            end
            if (rd_ok) begin
                rptr <= rptr + (ADDRSIZE+1)'(1);
            end
            rd_err <= rd_en && empty;
        end
    end

endmodule
